// File: rtl/pool_buf_defs.sv
// pool_buf_defs: read-FSM encoding, bank count and frame-size helper.
// POOL_FRAME_BUF_PINGPONG_EN selects two banks; otherwise one bank.
package pool_buf_defs;

    localparam logic [1:0] RD_IDLE   = 2'd0;
    localparam logic [1:0] RD_FILL   = 2'd1;
    localparam logic [1:0] RD_STREAM = 2'd2;

`ifdef POOL_FRAME_BUF_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    // extra RAM address bits spent on the bank select
    localparam int BANK_AW = (NUM_BANKS > 1) ? 1 : 0;

    function automatic int frame_size(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/pool_buf_ram.sv
// pool_buf_ram: simple dual-port RAM, one write port, one registered read.
// Ports: CLK, WE/WADDR/WDATA write side, RE/RADDR/RDATA read side.
module pool_buf_ram #(
    parameter int AW = 6,
    parameter int DW = 24
) (
    input  logic          CLK,
    input  logic          WE,
    input  logic [AW-1:0] WADDR,
    input  logic [DW-1:0] WDATA,
    input  logic          RE,
    input  logic [AW-1:0] RADDR,
    output logic [DW-1:0] RDATA
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[WADDR] <= WDATA;
        end
        if (RE) begin
            RDATA <= mem[RADDR];
        end
    end

endmodule

// File: rtl/pool_frame_buffer.sv
// pool_frame_buffer: captures one pooled map, replays it over VALID/READY.
// Ports: CLK, RSTn (sync, active-low); DIN_* capture stream; DOUT_* replay
// stream; LAST_PIX_DONE pulse; OVERFLOW / FRAME_ERR sticky flags.
// Macro POOL_FRAME_BUF_PINGPONG_EN enables two ping-pong banks.
module pool_frame_buffer
    import pool_buf_defs::*;
#(
    parameter int P_OUT_W  = 8,
    parameter int P_OUT_H  = 8,
    parameter int P_ADDR_W = 6,
    parameter int DW       = 24
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          DIN_VALID,
    input  logic [DW-1:0] DIN,
    input  logic          DIN_LAST_LINE,
    input  logic          DIN_LAST_PIX,
    output logic          DOUT_VALID,
    input  logic          DOUT_READY,
    output logic [DW-1:0] DOUT,
    output logic          DOUT_LAST,
    output logic          LAST_PIX_DONE,
    output logic          OVERFLOW,
    output logic          FRAME_ERR
);

    localparam int N      = frame_size(P_OUT_W, P_OUT_H);
    localparam int RAM_AW = P_ADDR_W + BANK_AW;
    localparam int COL_W  = (P_OUT_W > 1) ? $clog2(P_OUT_W) : 1;
    localparam logic [P_ADDR_W-1:0] LAST_ADDR = P_ADDR_W'(N - 1);
    localparam logic [COL_W-1:0]    LAST_COL  = COL_W'(P_OUT_W - 1);

    // ---------------- write side ----------------
    logic [P_ADDR_W-1:0] wr_addr;
    logic [COL_W-1:0]    wr_col;
    logic                wr_full;
    logic                wr_fire;
    logic                at_last;
    logic                line_end;
    logic                commit;
    logic                bad_pos;

    assign wr_fire  = DIN_VALID & ~wr_full;
    assign at_last  = (wr_addr == LAST_ADDR);
    assign line_end = (wr_col == LAST_COL);
    assign commit   = wr_fire & (DIN_LAST_PIX | at_last);
    assign bad_pos  = (DIN_LAST_PIX != at_last)
                    | (DIN_LAST_LINE != line_end);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wr_addr   <= '0;
            wr_col    <= '0;
            OVERFLOW  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            if (DIN_VALID & wr_full) begin
                OVERFLOW <= 1'b1;
            end
            if (wr_fire & bad_pos) begin
                FRAME_ERR <= 1'b1;
            end
            if (commit) begin
                wr_addr <= '0;
                wr_col  <= '0;
            end else if (wr_fire) begin
                wr_addr <= wr_addr + 1'b1;
                wr_col  <= line_end ? '0 : wr_col + 1'b1;
            end
        end
    end

    // ---------------- bank bookkeeping ----------------
    logic                rel;
    logic                rd_full;
    logic [P_ADDR_W-1:0] rd_len;
    logic [P_ADDR_W-1:0] ra;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [RAM_AW-1:0]   ram_raddr;

`ifdef POOL_FRAME_BUF_PINGPONG_EN
    logic                wr_bank;
    logic                rd_bank;
    logic [1:0]          full;
    logic [P_ADDR_W-1:0] blen [2];

    assign wr_full   = full[wr_bank];
    assign rd_full   = full[rd_bank];
    assign rd_len    = blen[rd_bank];
    assign ram_waddr = {wr_bank, wr_addr};
    assign ram_raddr = {rd_bank, ra};

    // commit and release never hit the same bank in one cycle:
    // commit needs it empty, release needs it full
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (commit) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (rel) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    // last index of each committed frame (short frames end early)
    always_ff @(posedge CLK) begin
        if (commit) begin
            blen[wr_bank] <= wr_addr;
        end
    end
`else
    logic                full;
    logic [P_ADDR_W-1:0] blen;

    assign wr_full   = full;
    assign rd_full   = full;
    assign rd_len    = blen;
    assign ram_waddr = wr_addr;
    assign ram_raddr = ra;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            full <= 1'b0;
        end else if (commit) begin
            full <= 1'b1;
        end else if (rel) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (commit) begin
            blen <= wr_addr;
        end
    end
`endif

    // ---------------- read FSM ----------------
    logic [1:0] rd_state;
    logic [1:0] rd_next;
    logic       rd_active;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            RD_IDLE:   if (rd_full) rd_next = RD_FILL;
            RD_FILL:   rd_next = RD_STREAM;
            RD_STREAM: if (rel) rd_next = RD_IDLE;
            default:   rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_active = 1'b0;
        unique case (rd_state)
            RD_FILL, RD_STREAM: rd_active = 1'b1;
            default:            rd_active = 1'b0;
        endcase
    end

    // ---------------- read issue + skid ----------------
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] sk_data [2];
    logic [1:0]    sk_last;
    logic          sk_wp;
    logic          sk_rp;
    logic [1:0]    sk_cnt;
    logic          rd_pend;
    logic          pend_last;
    logic          iss_done;
    logic          pop;
    logic          issue;
    logic [2:0]    occ;

    assign pop = DOUT_VALID & DOUT_READY;
    assign occ = {1'b0, sk_cnt} + {2'b0, rd_pend};

    // skid plus in-flight word may never exceed two entries
    assign issue = rd_active & ~iss_done
                 & ((occ < 3'd2) | ((occ == 3'd2) & pop));

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ra        <= '0;
            iss_done  <= 1'b0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            rd_pend <= issue;
            if (!rd_active) begin
                ra       <= '0;
                iss_done <= 1'b0;
            end else if (issue) begin
                pend_last <= (ra == rd_len);
                if (ra == rd_len) begin
                    iss_done <= 1'b1;
                end else begin
                    ra <= ra + 1'b1;
                end
            end
        end
    end

    pool_buf_ram #(
        .AW (RAM_AW),
        .DW (DW)
    ) u_ram (
        .CLK   (CLK),
        .WE    (wr_fire),
        .WADDR (ram_waddr),
        .WDATA (DIN),
        .RE    (issue),
        .RADDR (ram_raddr),
        .RDATA (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sk_data[0] <= '0;
            sk_data[1] <= '0;
            sk_last    <= '0;
            sk_wp      <= 1'b0;
            sk_rp      <= 1'b0;
            sk_cnt     <= '0;
        end else begin
            if (rd_pend) begin
                sk_data[sk_wp] <= ram_rdata;
                sk_last[sk_wp] <= pend_last;
                sk_wp          <= ~sk_wp;
            end
            if (pop) begin
                sk_rp <= ~sk_rp;
            end
            sk_cnt <= sk_cnt + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

    assign DOUT_VALID    = (sk_cnt != 2'd0);
    assign DOUT          = sk_data[sk_rp];
    assign DOUT_LAST     = DOUT_VALID & sk_last[sk_rp];
    assign rel           = pop & DOUT_LAST;
    assign LAST_PIX_DONE = rel;

endmodule

// File: tb/tb_pool_frame_buffer.sv
// tb_pool_frame_buffer: directed checks of capture, replay, stall,
// ping-pong/single-bank overflow, short frame and mid-frame reset.
module tb_pool_frame_buffer;

    localparam int DW = 24;

    typedef logic [DW+1:0] wr_t;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          DIN_VALID = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic          DIN_LAST_LINE = 1'b0;
    logic          DIN_LAST_PIX = 1'b0;
    logic          DOUT_VALID;
    logic          DOUT_READY = 1'b0;
    logic [DW-1:0] DOUT;
    logic          DOUT_LAST;
    logic          LAST_PIX_DONE;
    logic          OVERFLOW;
    logic          FRAME_ERR;

    pool_frame_buffer #(
        .P_OUT_W  (8),
        .P_OUT_H  (8),
        .P_ADDR_W (6),
        .DW       (DW)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .DIN_VALID     (DIN_VALID),
        .DIN           (DIN),
        .DIN_LAST_LINE (DIN_LAST_LINE),
        .DIN_LAST_PIX  (DIN_LAST_PIX),
        .DOUT_VALID    (DOUT_VALID),
        .DOUT_READY    (DOUT_READY),
        .DOUT          (DOUT),
        .DOUT_LAST     (DOUT_LAST),
        .LAST_PIX_DONE (LAST_PIX_DONE),
        .OVERFLOW      (OVERFLOW),
        .FRAME_ERR     (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    wr_t         wq[$];
    logic [DW:0] got[$];
    int          got_step[$];
    int          step_no = 0;
    int          commit_step = 0;
    int          first_valid = -1;
    int          done_cnt = 0;
    int          done_bad = 0;
    bit          ready_mode = 1'b0;
    bit          prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        wr_t w;
        @(negedge CLK);
        step_no++;
        if (wq.size() > 0) begin
            w = wq.pop_front();
            DIN_VALID     = 1'b1;
            DIN           = w[DW-1:0];
            DIN_LAST_LINE = w[DW];
            DIN_LAST_PIX  = w[DW+1];
            if (w[DW+1]) commit_step = step_no;
        end else begin
            DIN_VALID     = 1'b0;
            DIN           = '0;
            DIN_LAST_LINE = 1'b0;
            DIN_LAST_PIX  = 1'b0;
        end
        if (ready_mode)
            DOUT_READY = (step_no % 4 == 0) || (step_no % 4 == 3);
        else
            DOUT_READY = 1'b1;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 32'(DOUT_VALID), 1);
            chk("stall_hold", 32'({DOUT_LAST, DOUT}),
                32'(prev_word));
        end
        if (DOUT_VALID && first_valid < 0) first_valid = step_no;
        if (DOUT_VALID && DOUT_READY) begin
            got.push_back({DOUT_LAST, DOUT});
            got_step.push_back(step_no);
        end
        if (LAST_PIX_DONE) begin
            done_cnt++;
            if (!(DOUT_VALID && DOUT_READY && DOUT_LAST))
                done_bad++;
        end
        prev_stall = DOUT_VALID && !DOUT_READY;
        prev_word  = {DOUT_LAST, DOUT};
    endtask

    task automatic clear_obs();
        got.delete();
        got_step.delete();
        first_valid = -1;
        done_cnt    = 0;
        done_bad    = 0;
    endtask

    task automatic do_reset(input string tag);
        wq.delete();
        @(negedge CLK);
        RSTn          = 1'b0;
        DIN_VALID     = 1'b0;
        DIN_LAST_LINE = 1'b0;
        DIN_LAST_PIX  = 1'b0;
        DOUT_READY    = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        prev_stall = 1'b0;
        chk({tag, "_valid"}, 32'(DOUT_VALID), 0);
        chk({tag, "_dout"}, 32'(DOUT), 0);
        chk({tag, "_last"}, 32'(DOUT_LAST), 0);
        chk({tag, "_done"}, 32'(LAST_PIX_DONE), 0);
        chk({tag, "_ovf"}, 32'(OVERFLOW), 0);
        chk({tag, "_ferr"}, 32'(FRAME_ERR), 0);
    endtask

    task automatic push_frame(input int base, input int cnt,
                              input int pix_at);
        wr_t w;
        for (int i = 0; i < cnt; i++) begin
            w = {(i == pix_at), (i % 8 == 7), DW'(base + i)};
            wq.push_back(w);
        end
    endtask

    task automatic run(input string tag, input int exp_n);
        int n = 0;
        while ((wq.size() > 0 || got.size() < exp_n) && n < 2000) begin
            step();
            n++;
        end
        for (int i = 0; i < 8; i++) step();
        chk({tag, "_count"}, got.size(), exp_n);
    endtask

    task automatic chk_frame(input string tag, input int base,
                             input int cnt, input int off);
        logic [DW:0] e;
        for (int i = 0; i < cnt; i++) begin
            e = {(i == cnt - 1), DW'(base + i)};
            chk($sformatf("%s_w%0d", tag, i),
                32'(got[off + i]), 32'(e));
        end
    endtask

    initial begin
        // reset state
        do_reset("rst0");

        // T1: full frame, READY held high
        clear_obs();
        push_frame(0, 64, 63);
        run("t1", 64);
        chk_frame("t1", 0, 64, 0);
        chk("t1_latency", first_valid - commit_step, 4);
        chk("t1_contig", got_step[63] - got_step[0], 63);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_pos", done_bad, 0);
        chk("t1_ovf", 32'(OVERFLOW), 0);
        chk("t1_ferr", 32'(FRAME_ERR), 0);

        // T2: READY pattern 1,0,0,1
        clear_obs();
        ready_mode = 1'b1;
        push_frame(0, 64, 63);
        run("t2", 64);
        chk_frame("t2", 0, 64, 0);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_done_pos", done_bad, 0);
        ready_mode = 1'b0;

        // T3: second frame written while the first is read out
        clear_obs();
        push_frame(0, 64, 63);
        push_frame(100, 64, 63);
`ifdef POOL_FRAME_BUF_PINGPONG_EN
        run("t3", 128);
        chk_frame("t3a", 0, 64, 0);
        chk_frame("t3b", 100, 64, 64);
        chk("t3_done_cnt", done_cnt, 2);
        chk("t3_ovf", 32'(OVERFLOW), 0);
`else
        run("t3", 64);
        chk_frame("t3a", 0, 64, 0);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_ovf", 32'(OVERFLOW), 1);
`endif
        chk("t3_ferr", 32'(FRAME_ERR), 0);

        // T4: LAST_PIX early on word 40
        do_reset("rst4");
        clear_obs();
        push_frame(200, 41, 40);
        run("t4", 41);
        chk_frame("t4", 200, 41, 0);
        chk("t4_ferr", 32'(FRAME_ERR), 1);
        chk("t4_ovf", 32'(OVERFLOW), 0);
        chk("t4_done_cnt", done_cnt, 1);

        // T5: reset after 30 words, then a clean frame
        do_reset("rst5a");
        clear_obs();
        push_frame(300, 64, 63);
        for (int i = 0; i < 30; i++) step();
        do_reset("rst5b");
        clear_obs();
        push_frame(400, 64, 63);
        run("t5", 64);
        chk_frame("t5", 400, 64, 0);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_ferr", 32'(FRAME_ERR), 0);
        chk("t5_ovf", 32'(OVERFLOW), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
